// File: rtl/conf_mul_pass_ctrl.sv
// Phase/beat sequencer for the configurable-precision multiplier wrapper.
// Runs one load/row/column/flush pass per start and tracks products through the wrapper latency.
//   state | meaning
//   IDLE  | waiting for start, count0 parked at 0
//   LOAD  | operand load beats
//   ROW   | row-pass multiply beats
//   COL   | column-pass multiply beats
//   FLUSH | drain beats until the last product leaves the wrapper
module conf_mul_pass_ctrl #(
  parameter int unsigned LOAD_BEATS  = 64,
  parameter int unsigned ROW_BEATS   = 64,
  parameter int unsigned COL_BEATS   = 64,
  parameter int unsigned FLUSH_BEATS = 3,
  parameter int unsigned PROD_LAT    = 3
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic       apx_en,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_o,
  output logic [8:0] count0,
  output logic       racc,
  output logic       rapx,
  output logic       rstP,
  output logic       p_valid,
  output logic [5:0] p_idx,
  output logic       p_col
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    ROW   = 3'b010,
    COL   = 3'b011,
    FLUSH = 3'b100
  } state_t;

  state_t     state, state_nxt;
  logic [8:0] count_nxt;
  logic [8:0] last_idx;
  logic       ins_v;

  logic [PROD_LAT-1:0] pv;
  logic [PROD_LAT-1:0] pcol;
  logic [5:0]          pidx [PROD_LAT];

  always_comb begin
    last_idx = '0;
    unique case (state)
      LOAD:    last_idx = 9'(LOAD_BEATS - 1);
      ROW:     last_idx = 9'(ROW_BEATS - 1);
      COL:     last_idx = 9'(COL_BEATS - 1);
      FLUSH:   last_idx = 9'(FLUSH_BEATS - 1);
      default: last_idx = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count0;
    if (state == IDLE) begin
      count_nxt = '0;
      if (start) state_nxt = LOAD;
    end else if (!stall) begin
      if (count0 == last_idx) begin
        count_nxt = '0;
        unique case (state)
          LOAD:    state_nxt = ROW;
          ROW:     state_nxt = COL;
          COL:     state_nxt = FLUSH;
          FLUSH:   state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end else begin
        count_nxt = count0 + 9'd1;
      end
    end
  end

  // A product token enters the pipe only on an unstalled multiply beat.
  assign ins_v = !stall && ((state == ROW) || (state == COL));

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state  <= IDLE;
      count0 <= '0;
      racc   <= 1'b1;
      rstP   <= 1'b1;
      rapx   <= 1'b0;
      done   <= 1'b0;
      pv     <= '0;
      pcol   <= '0;
      for (int i = 0; i < int'(PROD_LAT); i++) pidx[i] <= '0;
    end else begin
      state  <= state_nxt;
      count0 <= count_nxt;
      racc   <= (state == IDLE) && start;
      rstP   <= (state_nxt == IDLE) || (state_nxt == LOAD);
      done   <= (state == FLUSH) && (state_nxt == IDLE);
      if (state_nxt == IDLE)  rapx <= 1'b0;
      else if (state == IDLE) rapx <= apx_en;
      pv[0]   <= ins_v;
      pcol[0] <= ins_v && (state == COL);
      pidx[0] <= ins_v ? count0[5:0] : 6'd0;
      for (int i = 1; i < int'(PROD_LAT); i++) begin
        pv[i]   <= pv[i-1];
        pcol[i] <= pcol[i-1];
        pidx[i] <= pidx[i-1];
      end
    end
  end

  assign busy    = (state != IDLE);
  assign state_o = state;
  assign p_valid = pv[PROD_LAT-1];
  assign p_col   = pcol[PROD_LAT-1];
  assign p_idx   = pidx[PROD_LAT-1];

endmodule
